// File: rtl/fb_scanout.sv
// fb_scanout: 640x480 VGA scanout of a 160x120 1-bit framebuffer, 4x4 replicated; FB_SCANOUT_CROSSHAIR_EN adds a zoom-centre crosshair
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int FB_W = 160,
  parameter logic [7:0] FG_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [18:0] read_addr,
  input  logic        read_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  rgb,
  output logic        frame_start
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [9:0] hcnt, vcnt;
  logic active, hs_n, vs_n, active_d1, hs_d1, vs_d1;
  logic [7:0] color, pix;
  assign active = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
  assign hs_n = !((hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n = !((vcnt >= 10'(V_ACTIVE + V_FP)) && (vcnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
  assign color = read_data ? FG_COLOR : BG_COLOR;
`ifdef FB_SCANOUT_CROSSHAIR_EN
  logic cross, cross_d1;
  assign cross = active && (hcnt[9:2] == 8'd80 || vcnt[9:2] == 8'd60);
  always_ff @(posedge clk)
    if (!rst_n) cross_d1 <= 1'b0;
    else if (pix_ce) cross_d1 <= cross;
  assign pix = color ^ {8{cross_d1}};
`else
  assign pix = color;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
      read_addr <= '0;
      active_d1 <= 1'b0;
      hs_d1 <= 1'b1;
      vs_d1 <= 1'b1;
      de <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && hcnt == '0 && vcnt == '0;
      if (pix_ce) begin
        hcnt <= (hcnt == 10'(H_TOT - 1)) ? '0 : hcnt + 10'd1;
        if (hcnt == 10'(H_TOT - 1)) vcnt <= (vcnt == 10'(V_TOT - 1)) ? '0 : vcnt + 10'd1;
        if (active) read_addr <= 19'(vcnt[9:2]) * 19'(FB_W) + 19'(hcnt[9:2]);
        active_d1 <= active;
        hs_d1 <= hs_n;
        vs_d1 <= vs_n;
        de <= active_d1;
        hsync <= hs_d1;
        vsync <= vs_d1;
        rgb <= active_d1 ? pix : 8'h00;
      end
    end
  end
endmodule
